// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding and ALUop constants for the ALU op sequencer.
package alu_seq_pkg;
  typedef enum logic [2:0] {IDLE, LD_A, LD_B, EXEC, WB} state_t;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;
endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller stepping regfile -> A/B -> ALU -> C -> write-back for one command.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int OP_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rn,
  input  logic [REG_AW-1:0] cmd_rm,
  output logic [REG_AW-1:0] readnum,
  output logic [REG_AW-1:0] writenum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              asel,
  output logic              loadc,
  output logic              loads,
  output logic [OP_W-1:0]   alu_op,
  output logic              done
);
  state_t              r_state, w_next;
  logic [OP_W-1:0]     r_op;
  logic [REG_AW-1:0]   r_rd, r_rn, r_rm;
  logic                w_accept;
  assign w_accept = cmd_valid && cmd_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_rd    <= '0;
      r_rn    <= '0;
      r_rm    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op <= cmd_op;
        r_rd <= cmd_rd;
        r_rn <= cmd_rn;
        r_rm <= cmd_rm;
      end
    end
  end
  // NOT only uses B, so it skips the A-operand load entirely
  always_comb begin
    w_next    = r_state;
    cmd_ready = r_state == IDLE;
    readnum   = r_state == LD_A ? r_rn : r_state == LD_B ? r_rm : '0;
    writenum  = r_state == WB ? r_rd : '0;
    loada     = r_state == LD_A;
    loadb     = r_state == LD_B;
    loadc     = r_state == EXEC;
    loads     = r_state == EXEC;
    asel      = r_state == EXEC && r_op == OP_W'(OP_NOT);
    write     = r_state == WB;
    done      = r_state == WB;
    alu_op    = r_state == IDLE ? '0 : r_op;
    case (r_state)
      IDLE:    w_next = w_accept ? (cmd_op == OP_W'(OP_NOT) ? LD_B : LD_A) : IDLE;
      LD_A:    w_next = LD_B;
      LD_B:    w_next = EXEC;
      EXEC:    w_next = WB;
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
endmodule
